// File: rtl/sobel_result_packer_pkg.sv
// Shared types and default constants for the Sobel result packer.
package sobel_packer_pkg;

  // Pixel width of the Sobel magnitude produced upstream.
  localparam int SOBEL_PIXEL_WIDTH = 8;

  localparam int DEF_PIXEL_WIDTH = SOBEL_PIXEL_WIDTH;
  localparam int DEF_WORD_PIXELS = 4;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_ADDR_WIDTH  = 16;
  localparam int DEF_BASE_ADDR   = 0;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    FLUSH,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/sobel_result_packer_sync_fifo.sv
// Single-clock FIFO. A push into a full FIFO is accepted when a pop happens
// in the same cycle. The head reads as zero while the FIFO is empty, so the
// data output has a defined value after reset without clearing storage.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage write; contents are qualified by r_count, so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sobel_result_packer.sv
// Captures Sobel pixels on the controller's completion edge, optionally
// binarizes them, packs them LSB-first into words, buffers the words and
// writes them to the frame buffer at consecutive word addresses.
module sobel_result_packer
  import sobel_packer_pkg::*;
#(
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int WORD_PIXELS = DEF_WORD_PIXELS,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int BASE_ADDR   = DEF_BASE_ADDR
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [PIXEL_WIDTH-1:0]           pixel_i,
  input  logic                             pixel_completed_i,
  input  logic                             prep_completed_i,
  input  logic                             binarize_en_i,
  input  logic [PIXEL_WIDTH-1:0]           threshold_i,
  output logic                             wr_valid_o,
  input  logic                             wr_ready_i,
  output logic [PIXEL_WIDTH*WORD_PIXELS-1:0] wr_data_o,
  output logic [ADDR_WIDTH-1:0]            wr_addr_o,
  output logic                             frame_done_o,
  output logic                             overflow_o
);

  localparam int WORD_W = PIXEL_WIDTH * WORD_PIXELS;
  localparam int LANE_W = (WORD_PIXELS > 1) ? $clog2(WORD_PIXELS) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(WORD_PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

  // Binarization: at-or-above threshold maps to all ones, else zero.
  function automatic logic [PIXEL_WIDTH-1:0] f_pixel(
    input logic [PIXEL_WIDTH-1:0] pix,
    input logic [PIXEL_WIDTH-1:0] thr,
    input logic                   bin
  );
    if (bin) return (pix >= thr) ? '1 : '0;
    return pix;
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_pix_prev;
  logic [LANE_W-1:0]       r_lane;
  logic [WORD_W-1:0]       r_word;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_overflow;

  logic                    w_edge;
  logic                    w_accept;
  logic                    w_last;
  logic                    w_lane_nz_nxt;
  logic                    w_frame_start;
  logic [PIXEL_WIDTH-1:0]  w_pix_val;
  logic [WORD_W-1:0]       w_word_full;
  logic                    w_push;
  logic [WORD_W-1:0]       w_push_data;
  logic                    w_pop;
  logic                    w_drop;
  logic                    w_full;
  logic                    w_empty;
  logic [CNT_W-1:0]        w_count;

  assign w_edge        = pixel_completed_i & ~r_pix_prev;
  assign w_accept      = w_edge & ((r_state == IDLE) | (r_state == COLLECT));
  assign w_last        = (r_lane == LAST_LANE);
  assign w_lane_nz_nxt = w_accept ? ~w_last : (r_lane != '0);
  assign w_frame_start = (r_state == IDLE) & (w_accept | prep_completed_i);
  assign w_pix_val     = f_pixel(pixel_i, threshold_i, binarize_en_i);
  assign w_push        = (w_accept & w_last) | (r_state == FLUSH);
  assign w_push_data   = (r_state == FLUSH) ? r_word : w_word_full;
  assign w_pop         = ~w_empty & wr_ready_i;
  assign w_drop        = w_push & w_full & ~w_pop;

  assign wr_valid_o    = ~w_empty;
  assign wr_addr_o     = r_addr;
  assign frame_done_o  = (r_state == DONE);
  assign overflow_o    = r_overflow;

  // Current word with the incoming pixel merged into its lane.
  always_comb begin
    w_word_full = r_word;
    w_word_full[int'(r_lane)*PIXEL_WIDTH +: PIXEL_WIDTH] = w_pix_val;
  end

  // Previous level of the completion flag, for rising-edge detection.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_pix_prev <= 1'b0;
    else         r_pix_prev <= pixel_completed_i;
  end

  // Lane packer; cleared after every push so a flushed word has zero upper lanes.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_lane <= '0;
      r_word <= '0;
    end else if (r_state == FLUSH) begin
      r_lane <= '0;
      r_word <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_lane <= '0;
        r_word <= '0;
      end else begin
        r_lane <= r_lane + 1'b1;
        r_word <= w_word_full;
      end
    end
  end

  // Write address and sticky overflow, both restarted at each frame start.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_addr     <= BASE;
      r_overflow <= 1'b0;
    end else begin
      if (w_frame_start)  r_addr <= BASE;
      else if (w_pop)     r_addr <= r_addr + 1'b1;
      if (w_drop)             r_overflow <= 1'b1;
      else if (w_frame_start) r_overflow <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state; DRAIN finishes on the cycle its last word is written.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept)              w_state_nxt = COLLECT;
        else if (prep_completed_i) w_state_nxt = DRAIN;
      end
      COLLECT: begin
        if (prep_completed_i) w_state_nxt = w_lane_nz_nxt ? FLUSH : DRAIN;
      end
      FLUSH: w_state_nxt = DRAIN;
      DRAIN: begin
        if (w_empty || (w_pop && (w_count == CNT_W'(1)))) w_state_nxt = DONE;
      end
      DONE: begin
        if (!prep_completed_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst   (reset_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_push_data),
    .o_rdata (wr_data_o),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

endmodule

// File: doc/sobel_result_packer.md
# sobel_result_packer

Downstream stage of the Sobel preprocessing engine. It captures each filtered pixel when the Sobel controller pulses its pixel-completed flag, and can optionally binarize it against a threshold. It packs pixels into memory words, buffers them in a small FIFO and writes them to the output frame buffer over a valid/ready write port. It signals frame completion once the controller reports end-of-frame and every word has been written.

## Interface
Parameters:
- PIXEL_WIDTH, 8, bits per Sobel pixel
- WORD_PIXELS, 4, pixels packed per write word (power of two)
- FIFO_DEPTH, 4, words of output buffering (power of two, ≥2)
- ADDR_WIDTH, 16, write address width (word addressing)
- BASE_ADDR, 0, address of the first word of each frame

Ports:
- clk_i  in  1  single clock, all logic rising-edge
- reset_i  in  1  asynchronous, active-high reset
- pixel_i  in  PIXEL_WIDTH  Sobel magnitude from controller
- pixel_completed_i  in  1  controller pixel flag; level may stay high after the final pixel
- prep_completed_i  in  1  controller end-of-frame level
- binarize_en_i  in  1  1: binarize, 0: pass magnitude; static during a frame
- threshold_i  in  PIXEL_WIDTH  binarization threshold; static during a frame
- wr_valid_o  out  1  write request
- wr_ready_i  in  1  write accept
- wr_data_o  out  PIXEL_WIDTH*WORD_PIXELS  packed word
- wr_addr_o  out  ADDR_WIDTH  word address
- frame_done_o  out  1  frame fully written
- overflow_o  out  1  sticky: a word was dropped this frame

## Operation
- Pixel accept: rising edge of pixel_completed_i, detected as current high and registered previous value low. Exactly one accept per edge; a held-high level does not re-accept.
- Pixel value: if binarize_en_i is set, pixel_i ≥ threshold_i gives all ones and anything else gives 0. Otherwise pixel_i passes unchanged.
- Packing: lane counter 0..WORD_PIXELS-1. Lane k occupies bits [k*PIXEL_WIDTH +: PIXEL_WIDTH], so the first pixel goes in the LSBs.
- When the last lane is accepted, the assembled word (including the current pixel) is pushed to the FIFO and the lane counter returns to 0.
- FIFO full on push:
  - If a pop occurs in the same cycle, the push succeeds.
  - Otherwise the word is dropped and overflow_o sets. It stays set until the next frame start or reset.
- Write port:
  - wr_valid_o = FIFO not empty; wr_data_o = FIFO head.
  - Transfer occurs on wr_valid_o && wr_ready_i.
  - wr_data_o and wr_addr_o stay stable while wr_valid_o && !wr_ready_i.
  - wr_addr_o starts at BASE_ADDR each frame and increments by 1 per transfer, wrapping modulo 2^ADDR_WIDTH.
- FSM states:
  - IDLE:
    - On a pixel accept, go to COLLECT; clear overflow_o and reset the address to BASE_ADDR.
    - On prep_completed_i, go to DRAIN (empty frame).
  - COLLECT: accept and pack pixels. On prep_completed_i, go to FLUSH if the lane counter ≠ 0, else to DRAIN.
  - FLUSH: one cycle. Push the partial word with unused lanes zero (same overflow rule), clear lanes, go to DRAIN.
  - DRAIN: ignore pixel edges. When the FIFO is empty, go to DONE.
  - DONE: frame_done_o = 1. When prep_completed_i falls, go to IDLE.
- prep_completed_i and a pixel edge in the same cycle in COLLECT: the pixel is accepted first (included in the flush decision), then the end-of-frame transition is taken.

## Timing
- Reset values: wr_valid_o 0, wr_data_o 0, wr_addr_o BASE_ADDR, frame_done_o 0, overflow_o 0. FSM in IDLE, lanes 0, FIFO empty.
- Reset asserted mid-frame discards all state immediately, including FIFO contents.
- Latency:
  - Edge in cycle t → pixel registered at end of t.
  - Completing word → wr_valid_o high in t+1, if the FIFO was empty.
- Sustained throughput: one word per cycle while wr_ready_i is high. The controller delivers at most one pixel per 11 cycles.
- frame_done_o rises the cycle after the last transfer empties the FIFO, or 1 cycle after DRAIN entry if already empty.

## Structure
- Package sobel_packer_pkg: state enum (IDLE, COLLECT, FLUSH, DRAIN, DONE) and default parameter constants; pixel width shared with the Sobel package.
- Sub-module sync_fifo: parameterised width/depth, push/pop/full/empty, simultaneous push+pop allowed when full.
- Top holds the edge detector, binarizer, lane packer, FSM and address counter.

## Test plan
- Full words, wr_ready_i held 1:
  - Stimulus: 8 pixel edges with values 1..8, then prep_completed_i.
  - Required: words 0x04030201 @ BASE_ADDR and 0x08070605 @ BASE_ADDR+1; frame_done_o one cycle after the second transfer.
- Partial flush:
  - Stimulus: 6 pixels 0x10..0x15, then prep_completed_i.
  - Required: second word 0x00001514; frame_done_o after it is written.
- Binarize with threshold 0x80:
  - Stimulus: pixels 0x7F, 0x80, 0x00, 0xFF.
  - Required: word 0xFF00FF00.
- Held level:
  - Stimulus: pixel_completed_i held high 20 cycles after one edge.
  - Required: exactly one pixel accepted.
- Backpressure and overflow:
  - Stimulus: wr_ready_i=0 throughout while 5 words are completed.
  - Required: first 4 buffered and the 5th dropped; overflow_o=1; wr_data_o stable.
  - Then raise wr_ready_i: 4 words written at consecutive addresses.
- Reset mid-frame:
  - Stimulus: assert reset_i after 2 pixels.
  - Required: all outputs at reset values; the next frame's first word starts at lane 0 @ BASE_ADDR.
